// File: rtl/fetch_buffer_pkg.sv
// Shared constants and state encoding for the instruction-fetch buffer.
package fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer_if.sv
// Cache-request, decode-handshake and redirect signals of the fetch buffer.
interface fetch_buffer_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_data_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    input  imem_valid_i, imem_data_i, id_stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    output imem_valid_i, imem_data_i, id_stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush and occupancy count; head is read combinationally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  // Pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_buffer.sv
// Sequential-PC fetch stage: one outstanding cache request, responses queued for decode,
// branch redirect flushes the queue and discards any in-flight response.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         outst_q, outst_d;

  logic          req, resp;
  logic [31:0]   redirect_tgt;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;

  assign redirect_tgt = bus.redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    outst_d    = outst_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    // A new request reserves a FIFO slot; an outstanding one is held until answered.
    // New requests are suppressed during a redirect so the old PC never escapes.
    req  = outst_q || (state_q == FETCH && !bus.redirect_i && fifo_count < DEPTH_C);
    resp = bus.imem_valid_i && outst_q;

    if (req && !outst_q) begin
      outst_d    = 1'b1;
      req_addr_d = fetch_pc_q;
    end
    if (resp) outst_d = 1'b0;

    if (bus.redirect_i) begin
      fifo_flush = 1'b1;
      fetch_pc_d = redirect_tgt;
      state_d    = (outst_q && !resp) ? DISCARD : FETCH;
    end else if (state_q == DISCARD) begin
      if (resp) state_d = FETCH;
    end else begin
      fifo_pop = !fifo_empty && !bus.id_stall_i;
      if (resp) begin
        fifo_push  = 1'b1;
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      fetch_pc_q <= PC_RESET;
      req_addr_q <= PC_RESET;
      outst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i ({fetch_pc_q, bus.imem_data_i}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign bus.imem_req_o  = req && !rst_i;
  assign bus.imem_addr_o = outst_q ? req_addr_q : fetch_pc_q;
  assign bus.id_valid_o  = !fifo_empty && !rst_i;
  assign bus.id_instr_o  = bus.id_valid_o ? fifo_head[31:0]  : NOP_INSTR;
  assign bus.id_pc_o     = bus.id_valid_o ? fifo_head[63:32] : 32'h0;
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_buffer_if bus();

  fetch_buffer #(.DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s_req, s_idv;
  logic [31:0] s_addr, s_instr, s_pc;

  // Reference model: queue of {pc, instr}, next fetch PC, pending request, discard flag.
  logic [63:0] mq[$];
  logic [31:0] m_fpc   = PC_RST;
  logic [31:0] m_paddr = PC_RST;
  bit          m_pend  = 1'b0;
  bit          m_disc  = 1'b0;

  // Bench-side cache: answers the pending request after a chosen delay.
  bit c_busy = 1'b0;
  int c_left = 0;

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] d;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_idv;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit st,
                     input bit rd, input logic [31:0] rpc);
    bit          e_req, e_idv, accept, issue;
    logic [31:0] e_addr, e_instr, e_pc;
    logic [63:0] head;
    rst               = r;
    bus.imem_valid_i  = v;
    bus.imem_data_i   = d;
    bus.id_stall_i    = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;

    head    = (mq.size() > 0) ? mq[0] : 64'h0;
    e_req   = !r && (m_pend || (!m_disc && !rd && mq.size() < DEPTH));
    e_addr  = m_pend ? m_paddr : m_fpc;
    e_idv   = !r && (mq.size() > 0);
    e_instr = e_idv ? head[31:0] : NOP_INSTR;
    e_pc    = e_idv ? head[63:32] : 32'h0;

    #4;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_idv   = bus.id_valid_o;
    s_instr = bus.id_instr_o;
    s_pc    = bus.id_pc_o;
    chk("req", {31'b0, s_req}, {31'b0, e_req});
    if (e_req) chk("addr", s_addr, e_addr);
    chk("id_valid", {31'b0, s_idv}, {31'b0, e_idv});
    chk("id_instr", s_instr, e_instr);
    chk("id_pc", s_pc, e_pc);
    if (s_idv && !st && !rd && !r)
      $display("decode takes pc=%h instr=%h", s_pc, s_instr);

    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_fpc  = PC_RST;
      m_pend = 1'b0;
      m_disc = 1'b0;
    end else begin
      accept = v && m_pend;
      issue  = e_req && !m_pend;
      if (rd) begin
        mq.delete();
        m_fpc = {rpc[31:2], 2'b00};
        if (accept) begin
          m_pend = 1'b0;
          m_disc = 1'b0;
        end else if (m_pend) begin
          m_disc = 1'b1;
        end
      end else if (m_disc) begin
        if (accept) begin
          m_pend = 1'b0;
          m_disc = 1'b0;
        end
      end else begin
        if (mq.size() > 0 && !st) void'(mq.pop_front());
        if (accept) begin
          mq.push_back({m_fpc, d});
          m_fpc  = m_fpc + 32'd4;
          m_pend = 1'b0;
        end
        if (issue) begin
          m_pend  = 1'b1;
          m_paddr = m_fpc;
        end
      end
    end
  endtask

  task automatic auto_cyc(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                          input int maxdelay);
    bit v;
    v = c_busy && (c_left == 0);
    cyc(r, v, $urandom, st, rd, rpc);
    if (r || v)      c_busy = 1'b0;
    else if (c_busy) c_left--;
    if (!r && m_pend && !c_busy) begin
      c_busy = 1'b1;
      c_left = $urandom_range(maxdelay, 0);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.imem_valid_i  = 1'b0;
    bus.imem_data_i   = 32'h0;
    bus.id_stall_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    @(posedge clk);
    #1;

    // Basic fetch: each instruction visible the cycle after its cache response.
    tbl[0] = '{1, 0, 32'h0,        0, 32'h0, 0, NOP_INSTR,    32'h0};
    tbl[1] = '{0, 0, 32'h0,        1, 32'h0, 0, NOP_INSTR,    32'h0};
    tbl[2] = '{0, 1, 32'h00500093, 1, 32'h0, 0, NOP_INSTR,    32'h0};
    tbl[3] = '{0, 0, 32'h0,        1, 32'h4, 1, 32'h00500093, 32'h0};
    tbl[4] = '{0, 1, 32'h00A00113, 1, 32'h4, 0, NOP_INSTR,    32'h0};
    tbl[5] = '{0, 0, 32'h0,        1, 32'h8, 1, 32'h00A00113, 32'h4};
    tbl[6] = '{0, 1, 32'h002081B3, 1, 32'h8, 0, NOP_INSTR,    32'h0};
    tbl[7] = '{0, 0, 32'h0,        1, 32'hC, 1, 32'h002081B3, 32'h8};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].d, 1'b0, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_idv", i), {31'b0, s_idv}, {31'b0, tbl[i].exp_idv});
      chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].exp_instr);
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].exp_pc);
    end

    // Stall with a zero-wait cache fills the FIFO, then one release pops one entry.
    c_busy = 1'b0;
    auto_cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) auto_cyc(0, 1, 0, 0, 0);
    chk("full_req_low", {31'b0, s_req}, 32'h0);
    chk("full_head_pc", s_pc, 32'h0);
    auto_cyc(0, 0, 0, 0, 0);
    auto_cyc(0, 1, 0, 0, 0);
    chk("after_pop_head", s_pc, 32'h4);
    chk("after_pop_req", {31'b0, s_req}, 32'h1);
    chk("after_pop_addr", s_addr, 32'h10);

    // Redirect with a slow outstanding request, then redirect coincident with a response.
    c_busy = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h11111111, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h22222222, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_redir_addr", s_addr, 32'h8);
    cyc(0, 0, 0, 0, 1, 32'h40);
    chk("redir_hold_req", {31'b0, s_req}, 32'h1);
    chk("redir_hold_addr", s_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("discard_addr", s_addr, 32'h8);
    chk("discard_idv", {31'b0, s_idv}, 32'h0);
    cyc(0, 1, 32'hDEADBEEF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("target_addr", s_addr, 32'h40);
    chk("target_idv", {31'b0, s_idv}, 32'h0);
    cyc(0, 1, 32'h00100093, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("target_head_pc", s_pc, 32'h40);
    chk("target_head_instr", s_instr, 32'h00100093);
    cyc(0, 1, 32'hBADBAD00, 0, 1, 32'h43);
    cyc(0, 0, 0, 0, 0, 0);
    chk("same_cycle_req", {31'b0, s_req}, 32'h1);
    chk("same_cycle_addr", s_addr, 32'h40);
    chk("same_cycle_idv", {31'b0, s_idv}, 32'h0);
    cyc(0, 1, 32'h00200113, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("same_cycle_head", s_pc, 32'h40);

    // Count 3 plus one outstanding; response and pop together keep the count.
    c_busy = 1'b0;
    auto_cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) auto_cyc(0, 1, 0, 0, 0);
    auto_cyc(0, 0, 0, 0, 0);
    auto_cyc(0, 1, 0, 0, 0);
    chk("pushpop_head", s_pc, 32'h4);
    chk("pushpop_addr", s_addr, 32'h10);
    auto_cyc(0, 1, 0, 0, 0);
    auto_cyc(0, 1, 0, 0, 0);
    chk("pushpop_full", {31'b0, s_req}, 32'h0);

    // Reset while discarding; a late response right after reset is ignored.
    c_busy = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h80);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h77777777, 0, 0, 0);
    chk("rst_disc_addr", s_addr, PC_RST);
    chk("rst_disc_req", {31'b0, s_req}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_disc_idv", {31'b0, s_idv}, 32'h0);
    cyc(0, 1, 32'h00300193, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_disc_head", s_pc, PC_RST);
    chk("rst_disc_instr", s_instr, 32'h00300193);

    // Randomized traffic against the reference model.
    c_busy = 1'b0;
    auto_cyc(1, 0, 0, 0, 3);
    for (int i = 0; i < 2000; i++) begin
      auto_cyc($urandom_range(199, 0) == 0, $urandom_range(2, 0) == 0,
               $urandom_range(19, 0) == 0, $urandom, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
